// File: rtl/pipeline_stage_skid.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer and a registered in_ready.
// Control is zeroed on bubbles; saturating bubble/stall counters.
module pipeline_stage_skid #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_pc2,
  input  logic [RA_W-1:0]   in_ra,
  input  logic [DATA_W-1:0] in_ea,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_pc2,
  output logic [DATA_W-1:0] out_ea,
  output logic [RA_W-1:0]   out_ra,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = 4*DATA_W + RA_W + CTRL_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   main_q, main_d;
  logic [BW-1:0]   skid_q, skid_d;
  logic [BW-1:0]   in_bundle;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic            in_fire, out_fire;

  assign in_bundle = {in_ctrl, in_ea, in_ra, in_pc2, in_b, in_a};

  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    bubble_d = bubble_q;
    stall_d  = stall_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_bundle;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_bundle;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_bundle;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops entries but leaves the data registers untouched; only ctrl is gated.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (!out_valid && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);

    if (rst) begin
      state_d  = EMPTY;
      main_d   = '0;
      skid_d   = '0;
      bubble_d = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    main_q   <= main_d;
    skid_q   <= skid_d;
    bubble_q <= bubble_d;
    stall_q  <= stall_d;
  end

  assign out_a      = main_q[DATA_W-1:0];
  assign out_b      = main_q[2*DATA_W-1:DATA_W];
  assign out_pc2    = main_q[3*DATA_W-1:2*DATA_W];
  assign out_ra     = main_q[3*DATA_W+RA_W-1:3*DATA_W];
  assign out_ea     = main_q[4*DATA_W+RA_W-1:3*DATA_W+RA_W];
  assign out_ctrl   = out_valid ? main_q[BW-1:4*DATA_W+RA_W] : '0;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
- Parametrised decode-to-execute pipeline stage register for the CPU pipeline.
- Carries operands, PC+2, destination register, effective address and a packed control bundle, using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered ready.
- Supports flush, zeroes control on bubbles so no stray writes occur, and provides saturating bubble/stall performance counters.

Parameters:
DATA_W, 8, width of A, B, PC2 and EA fields
RA_W, 2, width of destination register address
CTRL_W, 13, width of packed control bundle (lr_en, brx, alu_sel, wr_en, imm_sel, wb_sel, data_sel, reg_en)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all held entries (branch taken / exception)
in_valid  in  1  upstream (decode) has a valid bundle
in_ready  out  1  stage can accept a bundle this cycle
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_pc2  in  DATA_W  PC+2
in_ra  in  RA_W  destination register
in_ea  in  DATA_W  effective address / immediate
in_ctrl  in  CTRL_W  control bundle
out_valid  out  1  output bundle valid
out_ready  in  1  downstream (execute) accepts bundle
out_a, out_b, out_pc2, out_ea  out  DATA_W  registered fields
out_ra  out  RA_W  registered destination
out_ctrl  out  CTRL_W  registered control; forced 0 when out_valid=0
bubble_cnt  out  CNT_W  cycles with out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data is transferred only on a fire.
- Storage: main entry (drives out_*) and skid entry. Three states:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- in_ready:
  - Equals (state != FULL) & !rst; depends only on registered state, never on out_ready.
  - out_valid = (state != EMPTY).
- Transitions, evaluated when rst=0 and flush=0:
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Otherwise stay.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold both.
- Ordering and latency:
  - Strict FIFO order; no bundle is dropped or duplicated except by flush or rst.
  - Latency: 1 cycle from in_fire (from EMPTY) to out_valid.
  - Throughput: 1 bundle/cycle sustained while out_ready=1.
- flush=1 (rst=0):
  - Next state is EMPTY.
  - Any in_fire that cycle is accepted and discarded.
  - An out_fire that cycle completes normally downstream.
  - Data fields hold their values; out_ctrl reads 0 from the next cycle.
- Bubble gating:
  - out_ctrl = main_ctrl when out_valid=1, else all zeros.
  - out_a, out_b, out_pc2, out_ra, out_ea hold their last value when invalid.
- Reset (rst=1):
  - State is EMPTY next cycle; in_ready=0 during the rst cycle.
  - All main and skid fields are 0.
  - out_valid=0, out_ctrl=0, bubble_cnt=0, stall_cnt=0.
  - Inputs are ignored. Reset mid-operation discards both entries.
- Counters:
  - Updated only when rst=0.
  - bubble_cnt += 1 when out_valid=0.
  - stall_cnt += 1 when out_valid=1 and out_ready=0.
  - Both saturate at 2^CNT_W-1, with no wrap. Cleared only by rst; flush does not clear them.
- Simultaneous rst and flush: rst wins.
- Widths: all fields are pass-through with no arithmetic; counters are unsigned.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, all out_* = 0, in_ready=1 after rst drops, bubble_cnt=5, stall_cnt=0.
- Stream A=0x10..0x17 with in_valid=1 and out_ready=1 for 8 cycles -> out_a = 0x10..0x17 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Send 0x21, 0x22 with out_ready=0 -> state FULL, in_ready=0, out_a=0x21 held, stall_cnt increments per cycle. Raise out_ready -> 0x21 then 0x22 in order, in_ready=1 one cycle after first out_fire.
- FULL with ctrl=0x1FFF, assert flush -> next cycle out_valid=0, out_ctrl=0x0000, in_ready=1. Bundle presented during the flush cycle never appears at the output.
- Force CNT_W=4, hold out_valid=0 for 20 cycles -> bubble_cnt saturates at 15 without wrapping.
- rst asserted while FULL with flush=1 -> next cycle all outputs 0, counters 0, entries lost.
